// File: rtl/subleq_mem_arbiter.sv
// ---------------------------------------------------------------------------
// subleq_mem_arbiter
//
// Two-port arbiter in front of a single-ported memory. Each requester holds
// req/load/store/addr/wdata until it sees its one-cycle ack. Exactly one port
// owns the memory at a time; the owner's command is steered combinationally
// onto the memory side, and the memory's ack and read data are steered back to
// the owner in the same cycle. A one-cycle DONE state follows every completion
// so requesters can drop or change their request before re-arbitration.
//
// Ports
//   clk, areset           clock, asynchronous active-high reset
//   p0_* / p1_*           requester ports: req, load, store, addr, wdata in;
//                         ack, rdata out (rdata valid only in the ack cycle)
//   mem_req               registered, high while a port is granted
//   mem_load, mem_store,
//   mem_addr, mem_in      combinational copy of the granted port's command
//   mem_ack, mem_out      memory completion and read data
//   grant                 registered one-hot owner (bit n = port n), 0 = none
//
// Configuration macros
//   WORD_SIZE             data/address width (defaults to 16)
//   ARB_ROUND_ROBIN_EN    when defined, ties go to the port that did not win
//                         last; otherwise port 0 always wins ties.
// ---------------------------------------------------------------------------

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module subleq_mem_arbiter (
   input  logic                  clk,
   input  logic                  areset,

   input  logic                  p0_req,
   input  logic                  p0_load,
   input  logic                  p0_store,
   input  logic [`WORD_SIZE-1:0] p0_addr,
   input  logic [`WORD_SIZE-1:0] p0_wdata,
   output logic                  p0_ack,
   output logic [`WORD_SIZE-1:0] p0_rdata,

   input  logic                  p1_req,
   input  logic                  p1_load,
   input  logic                  p1_store,
   input  logic [`WORD_SIZE-1:0] p1_addr,
   input  logic [`WORD_SIZE-1:0] p1_wdata,
   output logic                  p1_ack,
   output logic [`WORD_SIZE-1:0] p1_rdata,

   output logic                  mem_req,
   output logic                  mem_load,
   output logic                  mem_store,
   output logic [`WORD_SIZE-1:0] mem_addr,
   output logic [`WORD_SIZE-1:0] mem_in,
   input  logic                  mem_ack,
   input  logic [`WORD_SIZE-1:0] mem_out,

   output logic [1:0]            grant
);

   localparam int unsigned WIDTH = `WORD_SIZE;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t state;

   // A request is only legal when exactly one of load/store is set.
   logic p0_elig;
   logic p1_elig;
   logic pick1;

   assign p0_elig = p0_req & (p0_load ^ p0_store);
   assign p1_elig = p1_req & (p1_load ^ p1_store);

`ifdef ARB_ROUND_ROBIN_EN
   // 1 = port 1 won the most recent grant; resets to 1 so the first tie
   // after reset goes to port 0.
   logic last_winner;

   assign pick1 = p1_elig & (~p0_elig | ~last_winner);
`else
   // Fixed priority: port 1 only wins when port 0 has nothing legal pending.
   assign pick1 = p1_elig & ~p0_elig;
`endif

   // Arbitration FSM; grant and mem_req are registered alongside the state.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state   <= IDLE;
         grant   <= 2'b00;
         mem_req <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_winner <= 1'b1;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (p0_elig | p1_elig) begin
                  state   <= pick1 ? GRANT1 : GRANT0;
                  grant   <= pick1 ? 2'b10 : 2'b01;
                  mem_req <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                  last_winner <= pick1;
`endif
               end
            end
            // The grant is held until memory completes, even if the owner
            // drops its request; the other port simply waits.
            GRANT0, GRANT1: begin
               if (mem_ack) begin
                  state   <= DONE;
                  grant   <= 2'b00;
                  mem_req <= 1'b0;
               end
            end
            // Single turnaround cycle; requests and mem_ack are ignored here.
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               grant   <= 2'b00;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   // Steer the owner's command to memory and the memory response back to
   // the owner; everything is zero when nobody owns the memory.
   always_comb begin
      mem_load  = 1'b0;
      mem_store = 1'b0;
      mem_addr  = WIDTH'(0);
      mem_in    = WIDTH'(0);
      p0_ack    = 1'b0;
      p0_rdata  = WIDTH'(0);
      p1_ack    = 1'b0;
      p1_rdata  = WIDTH'(0);

      unique case (state)
         GRANT0: begin
            mem_load  = p0_load;
            mem_store = p0_store;
            mem_addr  = p0_addr;
            mem_in    = p0_wdata;
            p0_ack    = mem_ack;
            p0_rdata  = mem_ack ? mem_out : WIDTH'(0);
         end
         GRANT1: begin
            mem_load  = p1_load;
            mem_store = p1_store;
            mem_addr  = p1_addr;
            mem_in    = p1_wdata;
            p1_ack    = mem_ack;
            p1_rdata  = mem_ack ? mem_out : WIDTH'(0);
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_subleq_mem_arbiter
//
// Directed bench for subleq_mem_arbiter. Requester tasks push the expected
// completion into a per-port queue; a negedge monitor pops and compares on
// every ack and also checks the idle/grant output invariants each cycle.
// A small memory model answers granted requests after a fixed latency.
// ---------------------------------------------------------------------------

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_subleq_mem_arbiter;

   localparam int W   = `WORD_SIZE;
   localparam int LAT = 2;

   logic         clk;
   logic         areset;
   logic         p0_req, p0_load, p0_store, p0_ack;
   logic [W-1:0] p0_addr, p0_wdata, p0_rdata;
   logic         p1_req, p1_load, p1_store, p1_ack;
   logic [W-1:0] p1_addr, p1_wdata, p1_rdata;
   logic         mem_req, mem_load, mem_store, mem_ack;
   logic [W-1:0] mem_addr, mem_in, mem_out;
   logic [1:0]   grant;

   // Memory response is the OR of the automatic model and manual injection.
   logic         auto_ack, man_ack, mem_auto;
   logic [W-1:0] auto_out, man_out;
   assign mem_ack = auto_ack | man_ack;
   assign mem_out = auto_ack ? auto_out : man_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         ld;
      logic [W-1:0] addr;
      logic [W-1:0] wdata;
      logic [W-1:0] rdata;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   ack_log[$];

   subleq_mem_arbiter dut (
      .clk      (clk),
      .areset   (areset),
      .p0_req   (p0_req),
      .p0_load  (p0_load),
      .p0_store (p0_store),
      .p0_addr  (p0_addr),
      .p0_wdata (p0_wdata),
      .p0_ack   (p0_ack),
      .p0_rdata (p0_rdata),
      .p1_req   (p1_req),
      .p1_load  (p1_load),
      .p1_store (p1_store),
      .p1_addr  (p1_addr),
      .p1_wdata (p1_wdata),
      .p1_ack   (p1_ack),
      .p1_rdata (p1_rdata),
      .mem_req  (mem_req),
      .mem_load (mem_load),
      .mem_store(mem_store),
      .mem_addr (mem_addr),
      .mem_in   (mem_in),
      .mem_ack  (mem_ack),
      .mem_out  (mem_out),
      .grant    (grant)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory model: ack LAT cycles after mem_req rises, one-cycle pulse.
   logic [W-1:0] mem_arr [0:255];
   initial begin
      int cnt;
      cnt = 0;
      auto_ack = 1'b0;
      auto_out = '0;
      for (int i = 0; i < 256; i++) mem_arr[i] = '0;
      mem_arr[8'h10] = W'(16'h1234);
      mem_arr[8'h30] = W'(16'hBEEF);
      mem_arr[8'h40] = W'(16'h4444);
      mem_arr[8'h50] = W'(16'h5555);
      forever begin
         @(posedge clk);
         #1;
         if (auto_ack) begin
            auto_ack = 1'b0;
            auto_out = '0;
            cnt = 0;
         end else if (mem_auto && mem_req) begin
            cnt++;
            if (cnt >= LAT) begin
               auto_ack = 1'b1;
               if (mem_load) auto_out = mem_arr[mem_addr[7:0]];
               else begin
                  mem_arr[mem_addr[7:0]] = mem_in;
                  auto_out = '0;
               end
            end
         end else begin
            cnt = 0;
         end
      end
   end

   task automatic check_ack(input int p);
      exp_t e;
      logic [W-1:0] rd;
      rd = (p == 0) ? p0_rdata : p1_rdata;
      if (p == 0 && q0.size() == 0) begin
         check("unexpected_ack_p0", 64'(p0_ack), 64'(0));
         return;
      end
      if (p == 1 && q1.size() == 0) begin
         check("unexpected_ack_p1", 64'(p1_ack), 64'(0));
         return;
      end
      e = (p == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("rdata_p%0d", p), 64'(rd), 64'(e.rdata));
      check($sformatf("mem_addr_p%0d", p), 64'(mem_addr), 64'(e.addr));
      check($sformatf("mem_type_p%0d", p), 64'({mem_load, mem_store}), 64'({e.ld, ~e.ld}));
      if (!e.ld) check($sformatf("mem_in_p%0d", p), 64'(mem_in), 64'(e.wdata));
      check($sformatf("grant_at_ack_p%0d", p), 64'(grant), (p == 0) ? 64'(2'b01) : 64'(2'b10));
      ack_log.push_back(p);
   endtask

   // Monitor: output invariants every cycle, scoreboard on each ack.
   always @(negedge clk) begin
      if (grant == 2'b00) begin
         check("quiet_when_ungranted",
               64'({mem_req, mem_load, mem_store, mem_addr, mem_in, p0_ack, p1_ack}), 64'(0));
      end else begin
         check("grant_onehot", 64'($countones(grant)), 64'(1));
         check("mem_req_when_granted", 64'(mem_req), 64'(1));
      end
      if (p0_ack && p1_ack) check("dual_ack", 64'(1), 64'(0));
      if (p0_ack) check_ack(0);
      if (p1_ack) check_ack(1);
   end

   task automatic drive(input int p, input logic r, input logic ld, input logic st,
                        input logic [W-1:0] a, input logic [W-1:0] d);
      if (p == 0) begin
         p0_req = r; p0_load = ld; p0_store = st; p0_addr = a; p0_wdata = d;
      end else begin
         p1_req = r; p1_load = ld; p1_store = st; p1_addr = a; p1_wdata = d;
      end
   endtask

   // Issue one transaction, hold it until ack, release during DONE.
   task automatic do_txn(input int p, input logic ld, input logic [W-1:0] addr,
                         input logic [W-1:0] wdata, input logic [W-1:0] rexp);
      exp_t e;
      logic got;
      e.ld = ld; e.addr = addr; e.wdata = wdata; e.rdata = rexp;
      if (p == 0) q0.push_back(e);
      else        q1.push_back(e);
      drive(p, 1'b1, ld, ~ld, addr, wdata);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = (p == 0) ? p0_ack : p1_ack;
      end
      check($sformatf("ack_seen_p%0d", p), 64'(got), 64'(1));
      @(posedge clk);
      #1;
      drive(p, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic check_order(input string name, input int n, input int exp_o[4]);
      check({name, "_count"}, 64'(ack_log.size()), 64'(n));
      for (int i = 0; i < n; i++)
         check(name, (ack_log.size() > i) ? 64'(ack_log[i]) : 64'(9), 64'(exp_o[i]));
   endtask

   initial begin
      #100000;
      errors++;
      checks++;
      $display("FAIL watchdog expired at %0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int ord[4];
      areset   = 1'b1;
      mem_auto = 1'b1;
      man_ack  = 1'b0;
      man_out  = '0;
      drive(0, 0, 0, 0, '0, '0);
      drive(1, 0, 0, 0, '0, '0);

      // Reset state
      @(negedge clk);
      check("rst_grant", 64'(grant), 64'(0));
      check("rst_mem_req", 64'(mem_req), 64'(0));
      check("rst_acks", 64'({p0_ack, p1_ack}), 64'(0));
      @(posedge clk); #1;
      areset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Single load: mem_req rises the cycle after the request is sampled
      fork
         do_txn(0, 1'b1, W'(16'h0010), '0, W'(16'h1234));
         begin
            #1;
            check("load_mem_req_before_sample", 64'(mem_req), 64'(0));
            @(posedge clk); #1;
            check("load_mem_req_after_sample", 64'(mem_req), 64'(1));
            check("load_grant", 64'(grant), 64'(2'b01));
         end
      join
      repeat (2) @(posedge clk);
      #1;

      // Simultaneous back-to-back requests from a fresh reset
      areset = 1'b1;
      #2;
      check("rst2_grant", 64'(grant), 64'(0));
      @(posedge clk); #1;
      areset = 1'b0;
      ack_log.delete();
      fork
         begin
            do_txn(0, 1'b1, W'(16'h0010), '0, W'(16'h1234));
            do_txn(0, 1'b1, W'(16'h0030), '0, W'(16'hBEEF));
         end
         begin
            do_txn(1, 1'b1, W'(16'h0040), '0, W'(16'h4444));
            do_txn(1, 1'b1, W'(16'h0050), '0, W'(16'h5555));
         end
      join
`ifdef ARB_ROUND_ROBIN_EN
      ord = '{0, 1, 0, 1};
`else
      ord = '{0, 0, 1, 1};
`endif
      check_order("tie_order", 4, ord);
      repeat (2) @(posedge clk);
      #1;

      // Store routing: p1 store wins, p0 load waits then is served
      ack_log.delete();
      fork
         do_txn(1, 1'b0, W'(16'h0020), W'(16'h00FF), '0);
         begin
            @(posedge clk); #1;
            do_txn(0, 1'b1, W'(16'h0030), '0, W'(16'hBEEF));
         end
      join
      ord = '{1, 0, 0, 0};
      check_order("store_order", 2, ord);
      do_txn(1, 1'b1, W'(16'h0020), '0, W'(16'h00FF));
      repeat (2) @(posedge clk);
      #1;

      // Illegal load=store request on p0 is never granted; p1 still served
      drive(0, 1'b1, 1'b1, 1'b1, W'(16'h0070), '0);
      fork
         begin
            repeat (2) @(posedge clk);
            #1;
            do_txn(1, 1'b1, W'(16'h0040), '0, W'(16'h4444));
         end
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("illegal_no_grant0", 64'(grant[0]), 64'(0));
         end
      join
      drive(0, 0, 0, 0, '0, '0);
      repeat (2) @(posedge clk);
      #1;

      // Reset mid-grant, late ack ignored, first tie afterwards goes to p0
      mem_auto = 1'b0;
      drive(0, 1'b1, 1'b1, 1'b0, W'(16'h0010), '0);
      @(posedge clk); #1;
      check("midrst_grant_before", 64'(grant), 64'(2'b01));
      check("midrst_mem_req_before", 64'(mem_req), 64'(1));
      #2;
      areset = 1'b1;
      #1;
      check("midrst_grant_async", 64'(grant), 64'(0));
      check("midrst_mem_req_async", 64'(mem_req), 64'(0));
      drive(0, 0, 0, 0, '0, '0);
      @(posedge clk); #1;
      areset  = 1'b0;
      man_out = W'(16'h1234);
      man_ack = 1'b1;
      @(negedge clk);
      check("late_ack_p0", 64'(p0_ack), 64'(0));
      @(posedge clk); #1;
      man_ack  = 1'b0;
      man_out  = '0;
      mem_auto = 1'b1;
      ack_log.delete();
      fork
         do_txn(0, 1'b1, W'(16'h0010), '0, W'(16'h1234));
         do_txn(1, 1'b1, W'(16'h0050), '0, W'(16'h5555));
      join
      ord = '{0, 1, 0, 0};
      check_order("post_rst_tie", 2, ord);
      repeat (2) @(posedge clk);
      #1;

      // Spurious mem_ack in IDLE
      mem_auto = 1'b0;
      man_out  = W'(16'h5A5A);
      man_ack  = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("spurious_idle_ack", 64'({p0_ack, p1_ack}), 64'(0));
         check("spurious_idle_grant", 64'(grant), 64'(0));
      end
      @(posedge clk); #1;
      man_ack = 1'b0;

      // Spurious mem_ack in DONE; a request held through DONE waits one cycle
      q0.push_back('{ld: 1'b1, addr: W'(16'h0060), wdata: '0, rdata: W'(16'hA5A5)});
      drive(0, 1'b1, 1'b1, 1'b0, W'(16'h0060), '0);
      @(posedge clk); #1;
      man_out = W'(16'hA5A5);
      man_ack = 1'b1;
      @(posedge clk); #1;
      man_out = W'(16'h9999);
      q0.push_back('{ld: 1'b1, addr: W'(16'h0060), wdata: '0, rdata: W'(16'h1111)});
      @(negedge clk);
      check("spurious_done_ack", 64'({p0_ack, p1_ack}), 64'(0));
      check("spurious_done_grant", 64'(grant), 64'(0));
      @(posedge clk); #1;
      man_ack = 1'b0;
      @(negedge clk);
      check("done_then_idle_grant", 64'(grant), 64'(0));
      @(posedge clk); #1;
      check("regrant_after_done", 64'(grant), 64'(2'b01));
      man_out = W'(16'h1111);
      man_ack = 1'b1;
      @(posedge clk); #1;
      man_ack = 1'b0;
      man_out = '0;
      drive(0, 0, 0, 0, '0, '0);
      check("q0_drained", 64'(q0.size()), 64'(0));
      check("q1_drained", 64'(q1.size()), 64'(0));

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/subleq_mem_arbiter.md
SUBLEQ_MEM_ARBITER -- requirements
Module: subleq_mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port areset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports p0_req/p1_req, input, 1, requester n transaction request, held until its ack.
REQ-004 SHALL have ports p0_load/p1_load and p0_store/p1_store, input, 1 each, transaction type, held with req.
REQ-005 SHALL have ports p0_addr/p1_addr and p0_wdata/p1_wdata, input, `WORD_SIZE each, address and store data, held with req.
REQ-006 SHALL have ports p0_ack/p1_ack, output, 1, one-cycle completion pulse to requester n.
REQ-007 SHALL have ports p0_rdata/p1_rdata, output, `WORD_SIZE, load data, valid in the ack cycle.
REQ-008 SHALL have memory-side ports mem_req, mem_load, mem_store (output, 1), mem_addr, mem_in (output, `WORD_SIZE), mem_ack (input, 1), mem_out (input, `WORD_SIZE).
REQ-009 SHALL have port grant, output, 2, one-hot current owner (bit n = port n), 0 when none.

Function
REQ-010 SHALL implement states IDLE, GRANT0, GRANT1, DONE.
REQ-011 IDLE: a port is eligible when req=1 and exactly one of load/store is 1; load==store requests SHALL be ignored and never acked.
REQ-012 IDLE, one eligible port: next state GRANTn; none: stay IDLE.
REQ-013 IDLE, both eligible: winner per REQ-024/REQ-025.
REQ-014 GRANTn: mem_req=1 (registered, first asserted the cycle after the winning request is sampled); mem_load/mem_store/mem_addr/mem_in driven combinationally from port n.
REQ-015 GRANTn, mem_ack=1: pn_ack=1 and pn_rdata=mem_out in that same cycle; next state DONE.
REQ-016 DONE lasts exactly one cycle, ignores all requests, then IDLE; requesters drop or change req during DONE.
REQ-017 Ungranted port: ack=0, rdata=0; when no grant, mem_req=mem_load=mem_store=0 and mem_addr=mem_in=0.
REQ-018 mem_ack outside GRANT0/GRANT1 SHALL be ignored and not forwarded.
REQ-019 A grant SHALL never be preempted; the other port's req waits, unacked, with no timeout.
REQ-020 Granted port dropping req before mem_ack SHALL NOT abort the memory transaction; arbiter stays in GRANTn until mem_ack.
REQ-021 Minimum transaction spacing per port: request sample -> ack = 1 + memory latency cycles, plus 1 DONE cycle before re-arbitration.

Reset
REQ-022 areset=1 SHALL immediately force state IDLE, grant=0, mem_req=0, all acks 0, last-winner register = port 1, independent of clk.
REQ-023 Reset during GRANTn SHALL abandon the transaction silently; a mem_ack arriving after reset release in IDLE is ignored per REQ-018.

Configuration
REQ-024 With macro ARB_ROUND_ROBIN_EN defined: on simultaneous eligible requests the port that did not win last SHALL win; last-winner register updates on each grant.
REQ-025 Without ARB_ROUND_ROBIN_EN: port 0 SHALL always win ties (fixed priority); last-winner register absent or unused.

Verification
REQ-026 Single load: p0 load addr 0x0010, memory returns 0x1234 after 2 cycles -> mem_req high cycle after sample, p0_ack pulse with p0_rdata=0x1234, DONE, IDLE; p1_ack stays 0.
REQ-027 Simultaneous: p0 and p1 both request in IDLE, back-to-back -> with ARB_ROUND_ROBIN_EN grants alternate 0,1,0,1; without it p0 wins every tie, p1 only served when p0_req=0 in IDLE.
REQ-028 Store routing: p1 store addr 0x0020 wdata 0x00FF while p0 holds load addr 0x0030 -> mem_addr=0x0020, mem_in=0x00FF, mem_store=1 during GRANT1; p0 then granted with mem_addr=0x0030.
REQ-029 Illegal request: p0_req=1 with load=store=1 for 10 cycles -> grant=0, mem_req=0, no ack; p1 legal request in same window served normally.
REQ-030 Reset mid-grant: areset pulsed during GRANT0 before mem_ack -> mem_req=0 and grant=0 without clock edge; late mem_ack pulse produces no p0_ack; first subsequent tie goes to port 0.
REQ-031 Spurious ack: mem_ack=1 in IDLE and in DONE -> no ack on either port, state unchanged.
